// File: rtl/paralelo_serialtx_pkg.sv
// Shared constants and state encoding for the byte-to-serial lane transmitter.
package paralelo_serialtx_pkg;

  localparam logic [7:0] COMMA_SYMBOL = 8'hBC;
  localparam int         COMMA_COUNT  = 4;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // comma_cnt holds at 7 instead of wrapping back into the preamble range.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/paralelo_serialtx_if.sv
// Byte-side handshake between the upstream mux and the serial transmitter.
// A byte transfers on a rising edge where valid_in and ready_out are both high; ready_out never
// depends on valid_in, and the master must hold data_in/valid_in stable until that edge.
interface paralelo_serialtx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (output data_in, output valid_in, input  ready_out);
  modport slave  (input  data_in, input  valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serialtx_piso_shift8.sv
// 8-bit parallel-load, shift-left register; bit 7 is the serial output.
module piso_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] q
);

  logic [7:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = load ? din : {shreg_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shreg_q <= 8'h00;
    else     shreg_q <= shreg_d;
  end

  assign q = shreg_q;

endmodule

// File: rtl/paralelo_serialtx.sv
// Lane transmitter: sends a comma preamble, then one byte per 8 bit-clocks MSB first,
// filling empty slots with commas so the receiver keeps sync.
module paralelo_serialtx
  import paralelo_serialtx_pkg::*;
(
  input  logic                clk_32f,
  input  logic                reset,
  paralelo_serialtx_if.slave  byte_if,
  output logic                data_out,
  output logic                active_out,
  output logic                comma_collision,
  output tx_state_e           state_dbg
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic       active_q, active_d;
  logic       coll_q, coll_d;
  logic       load;
  logic       accept;
  logic [7:0] frame;
  logic [7:0] shreg;

  always_comb begin
    load        = (bit_cnt_q == 3'd7);
    bit_cnt_d   = bit_cnt_q + 3'd1;
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    active_d    = active_q;
    coll_d      = 1'b0;
    accept      = 1'b0;
    frame       = COMMA_SYMBOL;

    case (state_q)
      ST_SYNC: begin
        if (load) begin
          comma_cnt_d = sat_inc3(comma_cnt_q);
          if (comma_cnt_q == 3'(COMMA_COUNT - 1)) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        accept = load && byte_if.valid_in;
        if (accept) frame = byte_if.data_in;
        // A data byte that looks like a comma is still sent; only flag it.
        coll_d = accept && (byte_if.data_in == COMMA_SYMBOL);
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      bit_cnt_q   <= 3'd7;
      comma_cnt_q <= 3'd0;
      active_q    <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      active_q    <= active_d;
      coll_q      <= coll_d;
    end
  end

  piso_shift8 u_piso (
    .clk  (clk_32f),
    .rst  (reset),
    .load (load),
    .din  (frame),
    .q    (shreg)
  );

  assign byte_if.ready_out = (state_q == ST_ACTIVE) && load && !reset;
  assign data_out          = shreg[7];
  assign active_out        = active_q;
  assign comma_collision   = coll_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_paralelo_serialtx.sv
// Bench for paralelo_serialtx: slot-level reference model, per-cycle compare, frame scoreboard.
module tb_paralelo_serialtx;
  import paralelo_serialtx_pkg::*;

  localparam logic [7:0] BC   = 8'hBC;
  localparam int         NPRE = 4;

  logic      clk_32f = 1'b0;
  logic      reset   = 1'b1;
  logic      data_out, active_out, comma_collision;
  tx_state_e state_dbg;

  paralelo_serialtx_if bif ();

  paralelo_serialtx dut (
    .clk_32f         (clk_32f),
    .reset           (reset),
    .byte_if         (bif),
    .data_out        (data_out),
    .active_out      (active_out),
    .comma_collision (comma_collision),
    .state_dbg       (state_dbg)
  );

  always #5 clk_32f = ~clk_32f;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: slot arithmetic since reset release ----------------
  int         n = 0;          // rising edges since reset release
  logic [7:0] cur_frame = 8'h00;
  logic       cur_coll  = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  int         coll_seen = 0;

  always @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      n = 0;
      cur_frame = 8'h00;
      cur_coll  = 1'b0;
      exp_q.delete();
    end else begin
      if (n % 8 == 0) begin
        if ((n / 8) < NPRE || !bif.valid_in) begin
          cur_frame = BC;
          cur_coll  = 1'b0;
        end else begin
          cur_frame = bif.data_in;
          cur_coll  = (bif.data_in == BC);
          sent_q.push_back(bif.data_in);
        end
        exp_q.push_back(cur_frame);
      end
      n++;
    end
  end

  // ---------------- per-cycle compare + serial receiver ----------------
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk_32f) begin
    logic e_data, e_ready, e_active, e_coll;
    int   ph;
    if (comma_collision) coll_seen++;
    if (reset) begin
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_active", 32'(active_out), 32'd0);
      chk("rst_ready", 32'(bif.ready_out), 32'd0);
      chk("rst_coll", 32'(comma_collision), 32'd0);
    end else begin
      if (n == 0) begin
        ph = 0; e_data = 1'b0; e_active = 1'b0; e_coll = 1'b0;
      end else begin
        ph       = (n - 1) % 8;
        e_data   = cur_frame[7 - ph];
        e_active = ((n - 1) / 8) >= (NPRE - 1);
        e_coll   = (ph == 0) && cur_coll;
      end
      e_ready = (n % 8 == 0) && ((n / 8) >= NPRE);
      chk("data_out", 32'(data_out), 32'(e_data));
      chk("ready_out", 32'(bif.ready_out), 32'(e_ready));
      chk("active_out", 32'(active_out), 32'(e_active));
      chk("comma_collision", 32'(comma_collision), 32'(e_coll));
      chk("state_dbg", 32'(state_dbg), 32'(e_active));
      if (n >= 1) begin
        rx_sh = {rx_sh[6:0], data_out};
        if (ph == 7) begin
          if (exp_q.size() > 0) chk("rx_frame", 32'(rx_sh), 32'(exp_q.pop_front()));
          else begin
            n_chk++; n_fail++;
            $display("FAIL rx_frame: got %0h with no frame expected", rx_sh);
          end
          if (rx_sh != BC) rx_q.push_back(rx_sh);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    bif.data_in  = b;
    bif.valid_in = 1'b1;
    while (!bif.ready_out && k < 40) begin
      @(negedge clk_32f);
      k++;
    end
    if (bif.ready_out) begin
      @(posedge clk_32f);
      @(negedge clk_32f);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: ready_out=0 after %0d cycles, required 1", k);
    end
    bif.valid_in = 1'b0;
  endtask

  task automatic wait_preamble(output int t, output logic [7:0] first8);
    t = 0;
    first8 = 8'h00;
    while (!bif.ready_out && t < 200) begin
      @(negedge clk_32f);
      t++;
      if (t >= 1 && t <= 8) first8[8 - t] = data_out;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         t, rc;
    logic [7:0] first8, bits;
    logic [7:0] lb [4];
    bif.data_in  = 8'h00;
    bif.valid_in = 1'b0;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C; lb[3] = 8'h81;

    repeat (3) @(negedge clk_32f);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_active", 32'(active_out), 32'd0);

    // 1: preamble
    reset = 1'b0;
    wait_preamble(t, first8);
    chk("preamble_first_frame", 32'(first8), 32'hBC);
    chk("preamble_len", 32'(t), 32'd32);
    chk("preamble_active", 32'(active_out), 32'd1);

    // 2: A5 MSB first, one ready pulse per slot
    send_byte(8'hA5);
    for (int j = 0; j < 8; j++) begin
      bits[7 - j] = data_out;
      @(negedge clk_32f);
    end
    chk("a5_bits", 32'(bits), 32'hA5);
    rc = 0;
    repeat (16) begin
      if (bif.ready_out) rc++;
      @(negedge clk_32f);
    end
    chk("ready_pulses_16clk", 32'(rc), 32'd2);

    // 3: idle slots
    coll_seen = 0;
    repeat (24) @(negedge clk_32f);
    chk("idle_no_collision", 32'(coll_seen), 32'd0);

    // 4: data byte equal to comma
    coll_seen = 0;
    send_byte(8'hBC);
    repeat (12) @(negedge clk_32f);
    chk("collision_once", 32'(coll_seen), 32'd1);

    // 5: reset mid-frame at bit 3 of 5A
    send_byte(8'h5A);
    repeat (4) @(negedge clk_32f);
    chk("pre_reset_bit3", 32'(data_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data_out", 32'(data_out), 32'd0);
    chk("async_rst_active", 32'(active_out), 32'd0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
    wait_preamble(t, first8);
    chk("re_preamble_first_frame", 32'(first8), 32'hBC);
    chk("re_preamble_len", 32'(t), 32'd32);

    // random traffic, including valid toggling between load edges
    repeat (400) begin
      bif.valid_in = 1'($urandom_range(0, 1));
      bif.data_in  = ($urandom_range(0, 7) == 0) ? BC : 8'($urandom_range(0, 255));
      @(negedge clk_32f);
    end
    bif.valid_in = 1'b0;
    repeat (16) @(negedge clk_32f);

    // 6: loopback of back-to-back bytes
    rx_q.delete();
    for (int i = 0; i < 4; i++) send_byte(lb[i]);
    repeat (20) @(negedge clk_32f);
    chk("loopback_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) chk("loopback_byte", 32'(rx_q[i]), 32'(lb[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
